// File: rtl/arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM state encoding,
// owner tags, the fixed fetch access size and parameter defaults.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int TIMEOUT_DEF      = 64;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive arbitration losses suffered by fetch.
// Clear has priority over increment; at_limit_o flags that fetch must win next.
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins, increment stops at LIMIT.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != 8'(LIMIT))) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q == 8'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store.
// Data has fixed priority; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive losses. All memory-side outputs are registered.
// Optional feature: define ARB_TIMEOUT_EN to abort accesses whose mem_ack does
// not arrive within TIMEOUT busy cycles (done + err pulse, read data 0).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Elaboration-time parameter sanity checks.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..255");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic eff_if_req;
  logic eff_d_req;
  logic grant_if;
  logic grant_d;
  logic complete;
  logic abort;
  logic timeout_hit;
  logic starve_at_limit;
  owner_e busy_owner;

  // A requester whose done pulse is high still shows its old request this
  // cycle; mask it so the finished access is not granted a second time.
  assign eff_if_req = if_req & ~if_done_q;
  assign eff_d_req  = d_req & ~d_done_q;
  assign busy_owner = (state_q == BUSY_IF) ? OWNER_IF : OWNER_D;

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc_i     ((state_q == IDLE) && eff_if_req && grant_d),
    .clr_i     (grant_if),
    .at_limit_o(starve_at_limit)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Busy-cycle counter: restarts on every grant, advances while no ack.
  always_comb begin
    wait_d = wait_q;
    if (grant_if || grant_d) begin
      wait_d = '0;
    end else if ((state_q != IDLE) && !mem_ack) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign timeout_hit = (state_q != IDLE) && (wait_q == WAIT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitration in IDLE, completion or abort in BUSY.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (eff_if_req && eff_d_req) begin
          if (starve_at_limit) begin
            grant_if = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
        end else if (eff_d_req) begin
          grant_d = 1'b1;
        end else if (eff_if_req) begin
          grant_if = 1'b1;
        end
        if (grant_if) begin
          state_d = BUSY_IF;
        end else if (grant_d) begin
          state_d = BUSY_D;
        end
      end
      BUSY_IF, BUSY_D: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (mem_ack) begin
          complete = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
        if (complete || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: load the winner on grant, pulse done on completion.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_size_d  = d_size;
    end else if (grant_if) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_size_d  = FUNCT3_WORD;
    end
    if (complete || abort) begin
      mem_req_d = 1'b0;
      err_d     = abort;
      if (busy_owner == OWNER_IF) begin
        if_done_d  = 1'b1;
        if_rdata_d = complete ? mem_rdata : '0;
      end else begin
        d_done_d  = 1'b1;
        // Stores return 0 rather than whatever the memory drove.
        d_rdata_d = (complete && !mem_we_q) ? mem_rdata : '0;
      end
    end
  end

  // Output registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and done pulses are
// queued as stimulus is set up, then matched as the DUT issues mem_req and
// done pulses. A memory model acks each grant after a queued latency.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_size;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_size;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } grant_t;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  grant_t      grant_q[$];
  done_t       done_q[$];
  int          lat_q[$];
  logic [31:0] data_q[$];

  grant_t      cur_g;
  int          cur_lat;
  int          cnt;
  logic [31:0] cur_data;
  logic        mem_req_prev;
  bit          ack_prev;
  bit          drop_if_pend;
  bit          drop_d_pend;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  int          n_chk;
  int          n_bad;
  int          cyc;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Observe the DUT just after a rising edge and drive the memory model and
  // requester responses for the next edge.
  task automatic monitor();
    done_t  e;
    grant_t g;
    cyc++;
    // Requesters are registered: they lower req one cycle after their done.
    if (drop_if_pend) begin if_req = 1'b0; drop_if_pend = 1'b0; end
    if (drop_d_pend)  begin d_req  = 1'b0; drop_d_pend  = 1'b0; end

    if (if_done || d_done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", {if_done, d_done}, 2'b00);
      end else begin
        e = done_q.pop_front();
        chk("done_owner", {if_done, d_done}, e.is_if ? 2'b10 : 2'b01);
        chk("done_err", err, e.err);
        if (e.is_if) begin
          chk("if_rdata", if_rdata, e.rdata);
          exp_if_rdata = e.rdata;
          drop_if_pend = 1'b1;
        end else begin
          chk("d_rdata", d_rdata, e.rdata);
          exp_d_rdata = e.rdata;
          drop_d_pend = 1'b1;
        end
        $display("txn %s rdata=%08h err=%0d cycle=%0d", e.is_if ? "fetch" : "data ",
                 e.rdata, e.err, cyc);
      end
    end else begin
      chk("err_quiet", err, 1'b0);
      chk("if_rdata_hold", if_rdata, exp_if_rdata);
      chk("d_rdata_hold", d_rdata, exp_d_rdata);
    end
    if (ack_prev) begin
      chk("ack_to_done", if_done | d_done, 1'b1);
      chk("req_drop", mem_req, 1'b0);
    end

    if (mem_req && !mem_req_prev) begin
      if (grant_q.size() == 0) begin
        chk("grant_unexpected", mem_req, 1'b0);
        cur_lat = -1;
      end else begin
        g = grant_q.pop_front();
        chk("grant_fields", {mem_we, mem_addr, mem_wdata, mem_size}, g);
        cur_g    = g;
        cur_lat  = lat_q.pop_front();
        cur_data = data_q.pop_front();
      end
      cnt = 0;
    end else if (mem_req) begin
      chk("mem_stable", {mem_we, mem_addr, mem_wdata, mem_size}, cur_g);
    end

    mem_ack   = 1'b0;
    ack_prev  = 1'b0;
    mem_rdata = $urandom();
    if (mem_req) begin
      if (cnt == cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = cur_data;
        ack_prev  = 1'b1;
      end
      cnt++;
    end
    mem_req_prev = mem_req;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((grant_q.size() != 0 || done_q.size() != 0 || mem_req ||
            drop_if_pend || drop_d_pend) && n < budget) begin
      step();
      n++;
    end
    chk("idle_budget", n < budget, 1'b1);
    if (n >= budget) begin
      grant_q.delete(); done_q.delete(); lat_q.delete(); data_q.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(if_done || d_done) && n < budget) begin
      step();
      n++;
    end
    chk("done_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    grant_q.delete(); done_q.delete(); lat_q.delete(); data_q.delete();
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    drop_if_pend = 1'b0;
    drop_d_pend  = 1'b0;
    repeat (cycles) begin
      step();
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_if_done", if_done, 1'b0);
      chk("rst_d_done", d_done, 1'b0);
      chk("rst_err", err, 1'b0);
    end
    rst = 1'b0;
  endtask

  // Queue a fetch: sets if_addr; the caller raises if_req.
  task automatic push_fetch(input logic [31:0] a, input int lat, input logic [31:0] data,
                            input logic err_exp);
    grant_t g;
    done_t  e;
    if_addr = a;
    g = '{we: 1'b0, addr: a, wdata: 32'h0, size: 3'b010};
    grant_q.push_back(g); lat_q.push_back(lat); data_q.push_back(data);
    e.is_if = 1'b1; e.rdata = err_exp ? 32'h0 : data; e.err = err_exp;
    done_q.push_back(e);
  endtask

  // Queue a data access: drives the d_* fields; the caller raises d_req.
  task automatic push_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] sz, input int lat, input logic [31:0] data,
                           input logic err_exp);
    grant_t g;
    done_t  e;
    d_we = we; d_addr = a; d_wdata = wd; d_size = sz;
    g = '{we: we, addr: a, wdata: wd, size: sz};
    grant_q.push_back(g); lat_q.push_back(lat); data_q.push_back(data);
    e.is_if = 1'b0; e.rdata = (we || err_exp) ? 32'h0 : data; e.err = err_exp;
    done_q.push_back(e);
  endtask

  initial begin
    int n;
    n_chk = 0; n_bad = 0; cyc = 0;
    mem_req_prev = 1'b0; ack_prev = 1'b0; cnt = 0; cur_lat = -1;
    cur_g = '0; cur_data = '0;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h1111_2222; d_size = 3'b100;

    // Reset with both requests up, then data wins; the fetch follows in the
    // cycle after d_done because the finished data request is masked.
    do_reset(2);
    push_data(1'b0, 32'h80, 32'h1111_2222, 3'b100, 1, 32'hAAAA_0001, 1'b0);
    push_fetch(32'h40, 0, 32'hBBBB_0002, 1'b0);
    step();
    chk("release_mem_req", mem_req, 1'b1);
    chk("release_mem_addr", mem_addr, 32'h80);
    wait_done(20);
    step();
    chk("spacing_mem_req", mem_req, 1'b1);
    chk("spacing_mem_addr", mem_addr, 32'h40);
    run_until_idle(40);

    // Single fetch, ack three cycles after mem_req.
    push_fetch(32'h100, 3, 32'h0050_0093, 1'b0);
    if_req = 1'b1;
    step();
    chk("fetch_req_latency", mem_req, 1'b1);
    run_until_idle(40);

    // Store: memory read data must not leak into d_rdata.
    push_data(1'b1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 2, 32'h5555_5555, 1'b0);
    d_req = 1'b1;
    run_until_idle(40);

    // A few loads with random address, size, latency and data.
    for (int i = 0; i < 4; i++) begin
      push_data(1'b0, $urandom() & 32'hFFFF_FFFC, $urandom(), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom(), 1'b0);
      d_req = 1'b1;
      run_until_idle(40);
    end

    // Starvation: fetch loses twice (withdrawing while it waits), then wins
    // the third contest outright.
    if_addr = 32'h700;
    for (int r = 0; r < SL; r++) begin
      push_data(1'b0, 32'h3000 + 32'(r * 4), 32'h0, 3'b010, 1, 32'h1000 + 32'(r), 1'b0);
      if_req = 1'b1; d_req = 1'b1;
      step();
      if_req = 1'b0;
      run_until_idle(40);
    end
    push_fetch(32'h700, 1, 32'h7777_0000, 1'b0);
    push_data(1'b0, 32'h3100, 32'h0, 3'b010, 0, 32'h3100_0000, 1'b0);
    if_req = 1'b1; d_req = 1'b1;
    run_until_idle(60);
    // Counter is back at zero: the next contest goes to data again.
    push_data(1'b0, 32'h3200, 32'h0, 3'b001, 0, 32'h3200_0000, 1'b0);
    push_fetch(32'h704, 0, 32'h7777_0004, 1'b0);
    if_req = 1'b1; d_req = 1'b1;
    run_until_idle(60);

    // Reset in the middle of a data access; a late ack while idle is ignored.
    push_data(1'b0, 32'h4000, 32'h0, 3'b010, -1, 32'h0, 1'b0);
    d_req = 1'b1;
    step();
    chk("midrst_grant", mem_req, 1'b1);
    step();
    d_req = 1'b0;
    do_reset(1);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    chk("stray_ack_d_done", d_done, 1'b0);
    chk("stray_ack_mem_req", mem_req, 1'b0);
    step();
    chk("stray_ack_idle", mem_req, 1'b0);
    chk("stray_ack_d_rdata", d_rdata, 32'h0);

`ifdef ARB_TIMEOUT_EN
    // Normal fetch, then one the memory never answers, then an ack that lands
    // exactly in the timeout cycle.
    push_fetch(32'h600, 1, 32'h1234_5678, 1'b0);
    if_req = 1'b1;
    run_until_idle(40);
    push_fetch(32'h500, -1, 32'h0, 1'b1);
    if_req = 1'b1;
    step();
    chk("to_grant", mem_req, 1'b1);
    n = 0;
    while (!if_done && n < 20) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    step();
    chk("to_req_low", mem_req, 1'b0);
    run_until_idle(20);
    push_fetch(32'h504, TO - 1, 32'hCAFE_F00D, 1'b0);
    if_req = 1'b1;
    run_until_idle(40);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
